// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_pkg;

  // Parity sense encodings for the PARITY_ODD parameter.
  localparam int unsigned PAR_EVEN = 0;
  localparam int unsigned PAR_ODD  = 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: strobes bit_end_c on the last cycle of a bit and
// restarts from zero on clear or after each strobe.
module uart_baud_gen #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] last,
  output logic             bit_end_c
);

  logic [CNT_W-1:0] count;

  assign bit_end_c = (count == last);

  // Count cycles within the current bit; wrap at every bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || bit_end_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a one-deep holding register for gapless frames.
// Optional feature macro: UART_TX_PARITY_EN (one parity bit after data).
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  output logic                 o_TX_Ready,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  // Reject illegal parameter combinations at elaboration.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != PAR_EVEN && PARITY_ODD != PAR_ODD) begin : g_bad_par
    $error("PARITY_ODD must be 0 or 1");
  end

  state_t               state_q, state_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic [DATA_BITS-1:0] hold_q, hold_n;
  logic                 hold_full_q, hold_full_n;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_n;
  logic                 serial_n, active_n, done_n, ready_n;
  logic                 accept_c;
  logic                 bit_end_c;
  logic [CNT_W-1:0]     last_c;

  assign accept_c = i_TX_DV && o_TX_Ready;
  assign last_c   = (state_q == STOP) ? STOP_LAST : BIT_LAST;

  uart_baud_gen #(
    .CNT_W (CNT_W)
  ) u_baud_gen (
    .clk       (i_Clock),
    .rst       (i_Rst),
    .clear     (state_q == IDLE),
    .last      (last_c),
    .bit_end_c (bit_end_c)
  );

  // Next-state, buffer management and next values of the registered outputs.
  always_comb begin
    state_n     = state_q;
    data_n      = data_q;
    hold_n      = hold_q;
    hold_full_n = hold_full_q;
    bit_idx_n   = bit_idx_q;
    done_n      = 1'b0;
    serial_n    = 1'b1;

    if (accept_c && state_q != IDLE) begin
      hold_n      = i_TX_Byte;
      hold_full_n = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          data_n    = i_TX_Byte;
          bit_idx_n = '0;
          state_n   = START;
        end
      end
      START: begin
        if (bit_end_c) state_n = DATA;
      end
      DATA: begin
        if (bit_end_c) begin
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n   = PARITY;
`else
            state_n   = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_c) state_n = STOP;
      end
`endif
      STOP: begin
        if (bit_end_c) begin
          done_n = 1'b1;
          if (hold_full_q) begin
            data_n      = hold_q;
            hold_full_n = 1'b0;
            state_n     = START;
          end else if (accept_c) begin
            // A byte arriving on the final stop cycle starts the next frame directly.
            data_n      = i_TX_Byte;
            hold_full_n = 1'b0;
            state_n     = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   serial_n = 1'b0;
      DATA:    serial_n = data_n[bit_idx_n];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_n = (^data_n) ^ (PARITY_ODD == PAR_ODD);
`endif
      default: serial_n = 1'b1;
    endcase

    active_n = (state_n != IDLE);
    ready_n  = !hold_full_n;
  end

  // State, datapath and output registers.
  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_idx_q   <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
      o_TX_Ready  <= 1'b1;
    end else begin
      state_q     <= state_n;
      data_q      <= data_n;
      hold_q      <= hold_n;
      hold_full_q <= hold_full_n;
      bit_idx_q   <= bit_idx_n;
      o_TX_Serial <= serial_n;
      o_TX_Active <= active_n;
      o_TX_Done   <= done_n;
      o_TX_Ready  <= ready_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: an 8N1 instance (even parity when
// enabled) and a 7-bit, 2-stop instance (odd parity when enabled).
module tb_uart_tx_cfg;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dv8 = 1'b0;
  logic [7:0] byte8 = 8'h00;
  logic       dv7 = 1'b0;
  logic [6:0] byte7 = 7'h00;
  logic       rdy8, act8, ser8, done8;
  logic       rdy7, act7, ser7, done7;

  int total = 0;
  int bad   = 0;
  logic [7:0] q[$];
  logic mon_abort = 1'b0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut8 (
    .i_Clock(clk), .i_Rst(rst), .i_TX_DV(dv8), .i_TX_Byte(byte8),
    .o_TX_Ready(rdy8), .o_TX_Active(act8), .o_TX_Serial(ser8), .o_TX_Done(done8));

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) u_dut7 (
    .i_Clock(clk), .i_Rst(rst), .i_TX_DV(dv7), .i_TX_Byte(byte7),
    .o_TX_Ready(rdy7), .o_TX_Active(act7), .o_TX_Serial(ser7), .o_TX_Done(done7));

  // Expected line level for bit slot idx of a frame (0 = start bit).
  function automatic logic exp_bit(input logic [8:0] d, input int db, input int odd, input int idx);
    logic p;
    p = odd[0];
    for (int k = 0; k < db; k++) p = p ^ d[k];
    if (idx == 0) return 1'b0;
    if (idx <= db) return d[4'(idx - 1)];
    if (PAR == 1 && idx == db + 1) return p;
    return 1'b1;
  endfunction

  task automatic mon_wait(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rst) mon_abort = 1'b1;
    end
  endtask

  // Line decoder for the 8-bit instance: samples mid-bit and scores frames.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] exp;
    logic st, par, sp;
    forever begin
      @(negedge clk);
      if (!rst && ser8 === 1'b0) begin
        mon_abort = 1'b0;
        mon_wait(2);
        st = ser8;
        for (int i = 0; i < 8; i++) begin
          mon_wait(4);
          got[i] = ser8;
        end
        par = 1'b1;
        if (PAR == 1) begin
          mon_wait(4);
          par = ser8;
        end
        mon_wait(4);
        sp = ser8;
        if (mon_abort) begin
          if (q.size() > 0) exp = q.pop_front();
        end else begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL monitor_extra_frame: got data %02h, required no frame", got);
          end else begin
            exp = q.pop_front();
            if ({st, got, par, sp} !== {1'b0, exp, exp_bit({1'b0, exp}, 8, 0, 9), 1'b1}) begin
              bad++;
              $display("FAIL monitor_frame: got st=%b data=%02h par=%b stop=%b, required data %02h",
                       st, got, par, sp, exp);
            end
          end
        end
      end
    end
  end

  task automatic test_reset;
    #2 rst = 1'b1;
    @(negedge clk);
    total++;
    if ({ser8, act8, done8, rdy8} !== 4'b1001) begin
      bad++;
      $display("FAIL reset8: got ser/act/done/rdy=%b, required 1001", {ser8, act8, done8, rdy8});
    end
    total++;
    if ({ser7, act7, done7, rdy7} !== 4'b1001) begin
      bad++;
      $display("FAIL reset7: got ser/act/done/rdy=%b, required 1001", {ser7, act7, done7, rdy7});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One frame on the selected instance; caller leaves time at a negedge.
  task automatic test_single(input int sel, input logic [8:0] d);
    int db, sb, odd, len;
    logic s, a, dn, r;
    db  = (sel == 1) ? 7 : 8;
    sb  = (sel == 1) ? 2 : 1;
    odd = (sel == 1) ? 1 : 0;
    len = 4 * (1 + db + PAR + sb);
    if (sel == 1) begin dv7 = 1'b1; byte7 = d[6:0]; end
    else begin dv8 = 1'b1; byte8 = d[7:0]; q.push_back(d[7:0]); end
    for (int c = 1; c <= len + 2; c++) begin
      @(negedge clk);
      dv7 = 1'b0;
      dv8 = 1'b0;
      s  = (sel == 1) ? ser7  : ser8;
      a  = (sel == 1) ? act7  : act8;
      dn = (sel == 1) ? done7 : done8;
      r  = (sel == 1) ? rdy7  : rdy8;
      total++;
      if (s !== ((c <= len) ? exp_bit(d, db, odd, (c - 1) / 4) : 1'b1)) begin
        bad++;
        $display("FAIL single_serial dut%0d cycle %0d: got %b, required %b", sel, c, s,
                 (c <= len) ? exp_bit(d, db, odd, (c - 1) / 4) : 1'b1);
      end
      total++;
      if ({a, dn, r} !== {(c <= len), (c == len + 1), 1'b1}) begin
        bad++;
        $display("FAIL single_ctrl dut%0d cycle %0d: got act/done/rdy=%b, required %b", sel, c,
                 {a, dn, r}, {(c <= len), (c == len + 1), 1'b1});
      end
    end
  endtask

  // 0x00 then 0xFF back to back, plus a third byte offered while holding is full.
  task automatic test_back_to_back;
    int len;
    logic es, er;
    len = 4 * (10 + PAR);
    dv8 = 1'b1; byte8 = 8'h00; q.push_back(8'h00);
    for (int c = 1; c <= 2 * len + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin byte8 = 8'hFF; q.push_back(8'hFF); end
      if (c == 2) byte8 = 8'h3C;
      if (c == 4) dv8 = 1'b0;
      es = (c <= len) ? exp_bit(9'h000, 8, 0, (c - 1) / 4) :
           (c <= 2 * len) ? exp_bit(9'h0FF, 8, 0, (c - 1 - len) / 4) : 1'b1;
      er = (c == 1) || (c > len);
      total++;
      if (ser8 !== es) begin
        bad++;
        $display("FAIL b2b_serial cycle %0d: got %b, required %b", c, ser8, es);
      end
      total++;
      if ({act8, done8, rdy8} !== {(c <= 2 * len), (c == len + 1 || c == 2 * len + 1), er}) begin
        bad++;
        $display("FAIL b2b_ctrl cycle %0d: got act/done/rdy=%b, required %b", c, {act8, done8, rdy8},
                 {(c <= 2 * len), (c == len + 1 || c == 2 * len + 1), er});
      end
    end
  endtask

  // Reset pulse during data bit 3, then a clean frame.
  task automatic test_reset_midframe;
    logic seen_done, seen_low;
    dv8 = 1'b1; byte8 = 8'h5A; q.push_back(8'h5A);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      dv8 = 1'b0;
      total++;
      if (ser8 !== exp_bit(9'h05A, 8, 0, (c - 1) / 4)) begin
        bad++;
        $display("FAIL midrst_serial cycle %0d: got %b, required %b", c, ser8,
                 exp_bit(9'h05A, 8, 0, (c - 1) / 4));
      end
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({ser8, act8, done8, rdy8} !== 4'b1001) begin
      bad++;
      $display("FAIL midrst_async: got ser/act/done/rdy=%b, required 1001", {ser8, act8, done8, rdy8});
    end
    @(negedge clk);
    #1 rst = 1'b0;
    seen_done = 1'b0;
    seen_low  = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done8 !== 1'b0) seen_done = 1'b1;
      if (ser8 !== 1'b1 || act8 !== 1'b0) seen_low = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_no_done: got done pulse, required none");
    end
    total++;
    if (seen_low !== 1'b0) begin
      bad++;
      $display("FAIL midrst_idle: got line activity after reset, required idle");
    end
    test_single(0, 9'h03C);
  endtask

  initial begin
    test_reset;
    test_single(0, 9'h0A5);
    test_single(1, 9'h07F);
    test_single(1, 9'h025);
    test_back_to_back;
    test_reset_midframe;
    repeat (10) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d frames outstanding, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, 217, clock cycles per serial bit; legal range is 2 or greater.
REQ-002 SHALL have parameter DATA_BITS, 8, data bits per frame; legal range is 5..9.
REQ-003 SHALL have parameter STOP_BITS, 1, stop bits per frame; legal values are 1 and 2.
REQ-004 SHALL have parameter PARITY_ODD, 0, parity sense (0 = even, 1 = odd); used only when UART_TX_PARITY_EN is defined.
REQ-005 SHALL have port i_Clock, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port i_Rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port i_TX_DV, input, 1, byte-valid strobe.
REQ-008 SHALL have port i_TX_Byte, input, DATA_BITS, data to send; LSB is sent first.
REQ-009 SHALL have port o_TX_Ready, output, 1, high when a byte can be accepted.
REQ-010 SHALL have port o_TX_Active, output, 1, high while a frame is on the line.
REQ-011 SHALL have port o_TX_Serial, output, 1, serial line; idle level is 1.
REQ-012 SHALL have port o_TX_Done, output, 1, one-cycle pulse per completed frame.

Function
REQ-013 SHALL accept a byte only in a cycle where i_TX_DV=1 and o_TX_Ready=1; i_TX_DV while o_TX_Ready=0 is ignored, with no side effect.
REQ-014 SHALL hold one byte in the shifter plus one byte in a one-deep holding register; o_TX_Ready = holding register empty.
REQ-015 SHALL load an accepted byte directly into the shifter when in IDLE with the holding register empty; otherwise it goes into the holding register.
REQ-016 SHALL use states IDLE, START, DATA, PARITY, STOP; transitions are IDLE->START on load, START->DATA, DATA->PARITY (when parity is compiled in) or DATA->STOP, and STOP->START (holding register full) or STOP->IDLE (empty).
REQ-017 SHALL drive o_TX_Serial low from the edge following acceptance in IDLE, i.e. 1 cycle of latency.
REQ-018 SHALL hold every start, data and parity bit for exactly CLKS_PER_BIT cycles, and the stop period for exactly STOP_BITS*CLKS_PER_BIT cycles at 1.
REQ-019 SHALL transmit data bits i_TX_Byte[0] through i_TX_Byte[DATA_BITS-1] in order, using a bit index that wraps to 0 after the last bit.
REQ-020 SHALL pulse o_TX_Done high for exactly one cycle, in the cycle after the last stop-bit cycle.
REQ-021 SHALL move a byte from holding to shifter with no idle gap between frames: the new start bit begins in the cycle after the last stop cycle, and o_TX_Ready rises on that same edge.
REQ-022 SHALL keep o_TX_Active high from the first start-bit cycle through the last stop-bit cycle; it stays high across back-to-back frames.
REQ-023 SHALL size the baud counter to hold CLKS_PER_BIT*STOP_BITS-1 without overflow; the counter clears at every bit boundary.

Reset
REQ-024 SHALL, on i_Rst=1, immediately set o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Ready=1, state IDLE, counters 0 and holding register empty.
REQ-025 SHALL, on reset mid-frame, abort the frame, discard the held byte, and emit no o_TX_Done pulse.
REQ-026 SHALL, in the first cycle after reset deasserts, accept i_TX_DV.

Configuration
REQ-027 SHALL, with UART_TX_PARITY_EN defined, insert one parity bit after the data bits: XOR of the data bits, inverted when PARITY_ODD=1.
REQ-028 SHALL, without UART_TX_PARITY_EN, contain no parity state or logic; the frame is start + data + stop.

Structure
REQ-029 SHALL place the state typedef (IDLE..STOP) and the parity-sense constants in shared package uart_pkg.
REQ-030 SHALL implement the bit-period counter as sub-module uart_baud_gen, which emits a bit-end strobe and restarts on a clear input.

Verification
REQ-031 SHALL cover: CLKS_PER_BIT=4, DATA_BITS=8, no parity, send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit; o_TX_Done in cycle 41 after accept.
REQ-032 SHALL cover: same setup with UART_TX_PARITY_EN, PARITY_ODD=0, send 0xA5 -> parity bit 0; done in cycle 45. With PARITY_ODD=1 -> parity bit 1.
REQ-033 SHALL cover: 0x00 accepted, then 0xFF on the next cycle -> both accepted, o_TX_Ready low until the second frame starts, no idle cycle between frames, and two Done pulses 40 cycles apart.
REQ-034 SHALL cover: third DV while holding is full -> ignored; only two frames are sent.
REQ-035 SHALL cover: DATA_BITS=7, STOP_BITS=2, send 0x7F -> 8 cycles of stop at 1; done in cycle 41.
REQ-036 SHALL cover: i_Rst pulse during data bit 3 -> o_TX_Serial=1 and o_TX_Active=0 at once, no Done pulse, and the next DV frame is correct.
